ram_scan_reader: RTL and testbench
==================================

RAM_SCAN_READER -- requirements
Module: ram_scan_reader

Interface
REQ-001 ADDR_WIDTH, 10, RAM address width; 2**ADDR_WIDTH entries.
REQ-002 DATA_WIDTH, 36, RAM entry width.
REQ-003 TAG_WIDTH, 20, tag field width; the tag is bits [DATA_WIDTH-1 : DATA_WIDTH-TAG_WIDTH], and bit 0 is the entry-valid flag.
REQ-004 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req_valid_i  in  1  search request valid.
REQ-008 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high at a rising edge.
REQ-009 req_tag_i  in  TAG_WIDTH  tag to find.
REQ-010 req_first_i  in  ADDR_WIDTH  first index to scan.
REQ-011 req_last_i  in  ADDR_WIDTH  last index to scan, inclusive.
REQ-012 ram_addr_o  out  ADDR_WIDTH  read address to the RAM port; the RAM registers it, so data returns one cycle later.
REQ-013 ram_data_i  in  DATA_WIDTH  RAM read data for the address presented in the previous cycle.
REQ-014 rsp_valid_o  out  1  response valid.
REQ-015 rsp_ready_i  in  1  response accepted when rsp_valid_o and rsp_ready_i are both high at a rising edge.
REQ-016 rsp_hit_o, rsp_idx_o, rsp_data_o  out  1/ADDR_WIDTH/DATA_WIDTH  hit flag, matching index, matching entry.
REQ-017 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-018 FSM states are IDLE, SCAN and RESP; req_ready_o SHALL be high only in IDLE.
REQ-019 Request acceptance (IDLE to SCAN) SHALL:
- latch the tag;
- load the address counter with req_first_i;
- clear the pending flag.
REQ-020 Each SCAN cycle SHALL:
- drive ram_addr_o from the address counter;
- increment the counter modulo 2**ADDR_WIDTH;
- set the pending flag, recording the issued index.
REQ-021 A SCAN cycle with the pending flag set SHALL compare ram_data_i: hit = bit 0 set AND tag field equal to the latched tag.
REQ-022 On a hit the block SHALL stop issuing addresses and enter RESP with rsp_hit_o=1, rsp_idx_o set to the recorded index and rsp_data_o set to ram_data_i; the lowest index in scan order wins.
REQ-023 If the compared index equals req_last_i and misses, the block SHALL enter RESP with rsp_hit_o=0, rsp_idx_o=req_last_i and rsp_data_o=0.
REQ-024 The block SHALL issue no address beyond req_last_i.
REQ-025 Wrap-around: if req_first_i > req_last_i, the scan SHALL run first..2**ADDR_WIDTH-1, then 0..last.
REQ-026 If req_first_i == req_last_i, exactly one entry SHALL be scanned.
REQ-027 Latency, with cycle 1 being the first cycle after the acceptance edge:
- a hit at scan offset n SHALL assert rsp_valid_o in cycle n+3;
- a full miss over L entries SHALL assert rsp_valid_o in cycle L+2.
REQ-028 In RESP, rsp_valid_o and all rsp_* outputs SHALL hold stable until the handshake completes, then the block SHALL return to IDLE; back-to-back requests need one IDLE cycle.
REQ-029 ram_addr_o SHALL hold its last value outside SCAN.
REQ-030 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-031 While rst_n is low at a rising edge the block SHALL set:
- state IDLE;
- rsp_valid_o=0, rsp_hit_o=0, rsp_idx_o=0, rsp_data_o=0;
- ram_addr_o=0, busy_o=0, pending flag cleared.
REQ-032 Reset asserted mid-SCAN or mid-RESP SHALL discard the operation with no response.
REQ-033 req_ready_o SHALL be 0 while rst_n is low, and 1 from the first cycle after release.

Configuration
REQ-034 Macro RAM_SCAN_READER_ABORT_EN: when defined, the block SHALL add input port abort_i (1 bit).
REQ-035 With RAM_SCAN_READER_ABORT_EN defined, abort_i high in SCAN at a rising edge SHALL force IDLE with no response; abort_i SHALL be ignored in IDLE and RESP.
REQ-036 With RAM_SCAN_READER_ABORT_EN undefined, the port SHALL be absent and every SCAN SHALL end in RESP.

Verification
REQ-037 Tag 0x12345 stored valid at index 5, request first=0, last=9 -> hit, idx=5, data equals the entry, rsp_valid_o in cycle 8.
REQ-038 No valid match in range, first=3, last=6 -> miss, idx=6, data=0, rsp_valid_o in cycle 6.
REQ-039 first=1022, last=1, match at index 0 only -> issued addresses 1022, 1023, 0; hit idx=0.
REQ-040 Matching tags at indices 2 and 4 (index 4 invalid-flagged too), first=0 -> hit idx=2; a tag match at an index with bit 0 = 0 SHALL miss.
REQ-041 rsp_ready_i held low for 5 cycles -> rsp_* stable throughout, req_ready_o=0; IDLE on the cycle after the handshake.
REQ-042 rst_n low in cycle 4 of a scan -> rsp_valid_o never asserts, ram_addr_o=0; with the macro defined, abort_i in cycle 3 -> IDLE with no response.

Source files
------------

// File: rtl/ram_scan_reader_if.sv
// Request/RAM/response bundle for ram_scan_reader; slave is the reader side,
// master is whoever issues requests, owns the RAM and consumes responses.
interface ram_scan_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int TAG_WIDTH  = 20
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [TAG_WIDTH-1:0]  req_tag_i;
  logic [ADDR_WIDTH-1:0] req_first_i;
  logic [ADDR_WIDTH-1:0] req_last_i;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_data_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_hit_o;
  logic [ADDR_WIDTH-1:0] rsp_idx_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_tag_i, req_first_i, req_last_i, ram_data_i, rsp_ready_i,
    output req_ready_o, ram_addr_o, rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_data_o, busy_o
  );
  modport master (
    output req_valid_i, req_tag_i, req_first_i, req_last_i, ram_data_i, rsp_ready_i,
    input  req_ready_o, ram_addr_o, rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_data_o, busy_o
  );
endinterface

// File: rtl/ram_scan_reader.sv
// Linear tag search over an index range of a 1-cycle-latency RAM, wrap-aware.
// Optional RAM_SCAN_READER_ABORT_EN adds abort_i to cancel a scan in flight.
module ram_scan_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int TAG_WIDTH  = 20
) (
  input logic clk,
  input logic rst_n,
`ifdef RAM_SCAN_READER_ABORT_EN
  input logic abort_i,
`endif
  ram_scan_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, last_q, pend_idx_q, addr_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  pend_q, done_q;
  logic                  rsp_hit_q;
  logic [ADDR_WIDTH-1:0] rsp_idx_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  hit, last_cmp, issue, abort, finish;

  always_comb begin
    hit      = pend_q && bus.ram_data_i[0] &&
               (bus.ram_data_i[DATA_WIDTH-1 -: TAG_WIDTH] == tag_q);
    last_cmp = pend_q && (pend_idx_q == last_q);
`ifdef RAM_SCAN_READER_ABORT_EN
    abort    = abort_i;
`else
    abort    = 1'b0;
`endif
    finish   = hit || last_cmp;
    // the address is withheld once the last index is out or a hit is seen
    issue    = (state_q == SCAN) && !done_q && !hit;
    state_d  = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid_i) state_d = SCAN;
      SCAN:    if (abort) state_d = IDLE;
               else if (finish) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      pend_idx_q <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid_i) begin
        tag_q  <= bus.req_tag_i;
        cnt_q  <= bus.req_first_i;
        last_q <= bus.req_last_i;
        pend_q <= 1'b0;
        done_q <= 1'b0;
      end
      if (issue) begin
        addr_q     <= cnt_q;
        cnt_q      <= cnt_q + 1'b1;
        pend_q     <= 1'b1;
        pend_idx_q <= cnt_q;
        done_q     <= (cnt_q == last_q);
      end
      if (state_q == SCAN && !abort && finish) begin
        rsp_hit_q  <= hit;
        rsp_idx_q  <= pend_idx_q;
        rsp_data_q <= hit ? bus.ram_data_i : '0;
      end
    end
  end

  assign bus.ram_addr_o  = issue ? cnt_q : addr_q;
  assign bus.req_ready_o = (state_q == IDLE) && rst_n;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_hit_o   = rsp_hit_q;
  assign bus.rsp_idx_o   = rsp_idx_q;
  assign bus.rsp_data_o  = rsp_data_q;
endmodule

// File: tb/tb_ram_scan_reader.sv
// Randomized + directed bench for ram_scan_reader against a loop-based search model.
module tb_ram_scan_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef RAM_SCAN_READER_ABORT_EN
  logic abort = 1'b0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [35:0] mem [1024];

  ram_scan_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(36), .TAG_WIDTH(20)) bus ();

  ram_scan_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(36), .TAG_WIDTH(20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef RAM_SCAN_READER_ABORT_EN
    .abort_i (abort),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // registered-address RAM: data for the address seen at an edge appears after it
  always @(posedge clk) bus.ram_data_i <= mem[bus.ram_addr_o];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [19:0] t, input bit v);
    return {t, 15'($urandom), v};
  endfunction

  task automatic clr(input logic [9:0] first, input int len);
    for (int k = 0; k < len; k++) mem[10'(first + 10'(k))][0] = 1'b0;
  endtask

  // scan first..last in order (wrapping), first valid tag match wins
  task automatic model(input logic [19:0] tag, input logic [9:0] first, last,
                       output logic ehit, output logic [9:0] eidx, output logic [35:0] edata,
                       output int lat, output int nis);
    logic [9:0] d, a;
    int len;
    d = last - first;
    len = int'(d) + 1;
    ehit = 1'b0; eidx = last; edata = '0; lat = len + 2; nis = len;
    for (int k = 0; k < len; k++) begin
      a = first + 10'(k);
      if (!ehit && mem[a][0] && mem[a][35:16] == tag) begin
        ehit = 1'b1; eidx = a; edata = mem[a]; lat = k + 3; nis = k + 1;
      end
    end
  endtask

  task automatic junk_req();
    bus.req_valid_i = 1'($urandom_range(0, 1));
    bus.req_tag_i   = 20'($urandom);
    bus.req_first_i = 10'($urandom);
    bus.req_last_i  = 10'($urandom);
  endtask

  task automatic run_txn(input logic [19:0] tag, input logic [9:0] first, last, input int stall,
                         output logic got_hit, output logic [9:0] got_idx);
    logic ehit;
    logic [9:0] eidx, ea, hold;
    logic [35:0] edata;
    int lat, nis, cyc;
    model(tag, first, last, ehit, eidx, edata, lat, nis);
    hold = first + 10'(nis - 1);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1; bus.req_tag_i = tag;
    bus.req_first_i = first; bus.req_last_i = last;
    @(negedge clk);
    cyc = 1;
    while (!bus.rsp_valid_o && cyc < 1100) begin
      ea = first + 10'(((cyc - 1) < nis) ? (cyc - 1) : (nis - 1));
      chk("scan_addr", bus.ram_addr_o, ea);
      chk("scan_ready", bus.req_ready_o, 0);
      junk_req();
      @(negedge clk);
      cyc++;
    end
    chk("rsp_cycle", cyc, lat);
    got_hit = bus.rsp_hit_o;
    got_idx = bus.rsp_idx_o;
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", bus.rsp_valid_o, 1);
      chk("rsp_hit", bus.rsp_hit_o, ehit);
      chk("rsp_idx", bus.rsp_idx_o, eidx);
      chk("rsp_data", bus.rsp_data_o, edata);
      chk("rsp_req_ready", bus.req_ready_o, 0);
      chk("rsp_busy", bus.busy_o, 1);
      chk("rsp_addr_hold", bus.ram_addr_o, hold);
      if (s < stall) begin
        junk_req();
        @(negedge clk);
      end
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid_o, 0);
    chk("post_req_ready", bus.req_ready_o, 1);
    chk("post_busy", bus.busy_o, 0);
  endtask

  initial begin
    logic h;
    logic [9:0] ix, f, l;
    logic [19:0] t;
    int quiet;
    for (int i = 0; i < 1024; i++) mem[i] = 36'({$urandom, $urandom});
    bus.req_valid_i = 1'b0; bus.req_tag_i = '0; bus.req_first_i = '0; bus.req_last_i = '0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_hit", bus.rsp_hit_o, 0);
    chk("rst_rsp_idx", bus.rsp_idx_o, 0);
    chk("rst_rsp_data", bus.rsp_data_o, 0);
    chk("rst_addr", bus.ram_addr_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", bus.req_ready_o, 1);

    // hit at index 5 of 0..9 -> response in cycle 8
    clr(0, 10); mem[5] = mk(20'h12345, 1'b1);
    run_txn(20'h12345, 10'd0, 10'd9, 0, h, ix);
    chk("d37_hit", h, 1); chk("d37_idx", ix, 5);

    // miss over 3..6 -> idx 6, cycle 6
    clr(3, 4);
    run_txn(20'h0ABCD, 10'd3, 10'd6, 1, h, ix);
    chk("d38_hit", h, 0); chk("d38_idx", ix, 6);

    // wrap 1022..1 with match only at 0
    clr(10'd1022, 4); mem[0] = mk(20'h55AA5, 1'b1);
    run_txn(20'h55AA5, 10'd1022, 10'd1, 0, h, ix);
    chk("d39_hit", h, 1); chk("d39_idx", ix, 0);

    // lowest index wins; invalid-flagged tag match does not count
    clr(0, 10); mem[2] = mk(20'h0F0F0, 1'b1); mem[4] = mk(20'h0F0F0, 1'b0);
    run_txn(20'h0F0F0, 10'd0, 10'd9, 0, h, ix);
    chk("d40_hit", h, 1); chk("d40_idx", ix, 2);
    mem[2][0] = 1'b0;
    run_txn(20'h0F0F0, 10'd0, 10'd9, 0, h, ix);
    chk("d40_inv_hit", h, 0); chk("d40_inv_idx", ix, 9);

    // response held for 5 stalled cycles; single-entry scan
    clr(100, 1); mem[100] = mk(20'h77777, 1'b1);
    run_txn(20'h77777, 10'd100, 10'd100, 5, h, ix);
    chk("d41_hit", h, 1); chk("d41_idx", ix, 100);
    mem[100][0] = 1'b0;
    run_txn(20'h77777, 10'd100, 10'd100, 0, h, ix);
    chk("single_miss", h, 0);

    // full-range miss (first = last+1)
    for (int i = 0; i < 1024; i++) mem[i][0] = 1'b0;
    run_txn(20'h13579, 10'd5, 10'd4, 0, h, ix);
    chk("full_miss_idx", ix, 4);
    for (int i = 0; i < 1024; i++) mem[i] = 36'({$urandom, $urandom});

    // reset in cycle 4 of a scan discards it
    clr(0, 201);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_tag_i = 20'hABCDE; bus.req_first_i = 0; bus.req_last_i = 200;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("mid_rst_addr", bus.ram_addr_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_ready", bus.req_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rel_ready", bus.req_ready_o, 1);
    quiet = 0;
    repeat (8) begin
      if (bus.rsp_valid_o || bus.busy_o) quiet++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", quiet, 0);

`ifdef RAM_SCAN_READER_ABORT_EN
    bus.req_valid_i = 1'b1; bus.req_tag_i = 20'hABCDE; bus.req_first_i = 0; bus.req_last_i = 200;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_ready", bus.req_ready_o, 1);
    quiet = 0;
    repeat (8) begin
      if (bus.rsp_valid_o || bus.busy_o) quiet++;
      @(negedge clk);
    end
    chk("abort_quiet", quiet, 0);
`endif

    // randomized ranges with planted (possibly invalid, possibly out-of-range) matches
    for (int n = 0; n < 30; n++) begin
      int span;
      t = 20'($urandom);
      f = 10'($urandom);
      span = $urandom_range(1, 48);
      l = f + 10'(span - 1);
      for (int p = 0; p < int'($urandom_range(0, 3)); p++)
        mem[10'(f + 10'($urandom_range(0, span + 3)))] = mk(t, 1'($urandom_range(0, 1)));
      run_txn(t, f, l, $urandom_range(0, 3), h, ix);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
